// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse stream decoder: FSM states,
// the A-Z/0-9 code table, ASCII constants and the 7-segment glyph table.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    GAP,
    WORD_WAIT
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [6:0] SEG_BLANK   = 7'h7F;

  // {len[2:0], pattern[4:0]}; the first element sent sits in the highest used bit.
  localparam logic [7:0] CODE_TABLE [36] = '{
    8'b010_00001, 8'b100_01000, 8'b100_01010, 8'b011_00100, // A B C D
    8'b001_00000, 8'b100_00010, 8'b011_00110, 8'b100_00000, // E F G H
    8'b010_00000, 8'b100_00111, 8'b011_00101, 8'b100_00100, // I J K L
    8'b010_00011, 8'b010_00010, 8'b011_00111, 8'b100_00110, // M N O P
    8'b100_01101, 8'b011_00010, 8'b011_00000, 8'b001_00001, // Q R S T
    8'b011_00001, 8'b100_00001, 8'b011_00011, 8'b100_01001, // U V W X
    8'b100_01011, 8'b100_01100,                             // Y Z
    8'b101_11111, 8'b101_01111, 8'b101_00111, 8'b101_00011, // 0 1 2 3
    8'b101_00001, 8'b101_00000, 8'b101_10000, 8'b101_11000, // 4 5 6 7
    8'b101_11100, 8'b101_11110                              // 8 9
  };

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}, for hex digits 0-F.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [7:0] decode_char(input logic [3:0] len,
                                             input logic [4:0] pattern);
    logic [7:0] ch;
    ch = ASCII_QMARK;
    for (int i = 0; i < 36; i++) begin
      if (len <= 4'd5 && CODE_TABLE[i] == {len[2:0], pattern}) begin
        ch = (i < 26) ? 8'h41 + 8'(i) : 8'h30 + 8'(i - 26);
      end
    end
    return ch;
  endfunction

endpackage

// File: rtl/morse_seg7_enc.sv
// Combinational ASCII to active-low 7-segment encoder: digits and A-F get
// hex glyphs, everything else is blank.
module morse_seg7_enc
  import morse_pkg::*;
(
  input  logic [7:0] char_code,
  output logic [6:0] seg
);

  logic [3:0] digit_idx;
  logic [3:0] hex_idx;

  assign digit_idx = 4'(char_code - 8'h30);
  assign hex_idx   = 4'(char_code - 8'h37);

  always_comb begin
    seg = SEG_BLANK;
    if (char_code >= 8'h30 && char_code <= 8'h39) begin
      seg = SEG_GLYPH[digit_idx];
    end else if (char_code >= 8'h41 && char_code <= 8'h46) begin
      seg = SEG_GLYPH[hex_idx];
    end
  end

endmodule

// File: rtl/morse_stream_decoder.sv
// Decodes a keyed Morse line into a stream of ASCII characters with a
// valid/ready output. Optional 7-segment output: define MORSE_STREAM_SEG7_EN.
module morse_stream_decoder
  import morse_pkg::*;
#(
  parameter int DOT_CYCLES    = 1000,
  parameter int GLITCH_CYCLES = 2,
  parameter int MAX_LEN       = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       morse_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_char,
  output logic       overflow
`ifdef MORSE_STREAM_SEG7_EN
  ,
  output logic [6:0] seg
`endif
);

  localparam int CW = $clog2(8 * DOT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_SAT     = CW'(8 * DOT_CYCLES);
  localparam logic [CW-1:0] CNT_LETTER  = CW'(2 * DOT_CYCLES);
  localparam logic [CW-1:0] CNT_WORD    = CW'(6 * DOT_CYCLES);
  // The counter holds mark length minus one when MARK is left.
  localparam logic [CW-1:0] CNT_GLITCH  = CW'(GLITCH_CYCLES - 1);
  localparam logic [CW-1:0] CNT_DASH    = CW'(2 * DOT_CYCLES - 1);
  localparam logic [3:0]    LEN_MAX     = 4'(MAX_LEN);

  logic [1:0]         sync_q;
  logic               m;
  state_t             state, state_next, pre_state;
  logic [CW-1:0]      cnt;
  logic [MAX_LEN-1:0] pattern;
  logic [3:0]         len;
  logic               cnt_clr, take_elem, letter_end, word_end;
  logic               push, load;
  logic [7:0]         push_char;
  logic               hi_zero;

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], morse_in};
  end
  assign m = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pre_state <= IDLE;
    end else begin
      state <= state_next;
      if (state != MARK && state_next == MARK) pre_state <= state;
    end
  end

  // NOTE: every output of this block gets a default first so no path
  // through the case leaves a latch behind.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    take_elem  = 1'b0;
    letter_end = 1'b0;
    word_end   = 1'b0;
    case (state)
      IDLE: begin
        if (m) begin
          state_next = MARK;
          cnt_clr    = 1'b1;
        end
      end
      MARK: begin
        if (!m) begin
          cnt_clr = 1'b1;
          if (cnt < CNT_GLITCH) begin
            state_next = pre_state;
          end else begin
            state_next = GAP;
            take_elem  = 1'b1;
          end
        end
      end
      GAP: begin
        if (m) begin
          state_next = MARK;
          cnt_clr    = 1'b1;
        end else if (cnt == CNT_LETTER) begin
          state_next = WORD_WAIT;
          letter_end = 1'b1;
        end
      end
      WORD_WAIT: begin
        if (m) begin
          state_next = MARK;
          cnt_clr    = 1'b1;
        end else if (cnt == CNT_WORD) begin
          state_next = IDLE;
          word_end   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                              cnt <= '0;
    else if (cnt_clr)                       cnt <= '0;
    else if (state != IDLE && cnt != CNT_SAT) cnt <= cnt + CW'(1);
  end

  // Elements past MAX_LEN only bump the length, which forces '?' at letter end.
  always_ff @(posedge clk) begin
    if (reset || letter_end) begin
      pattern <= '0;
      len     <= '0;
    end else if (take_elem) begin
      if (len < LEN_MAX) begin
        pattern <= {pattern[MAX_LEN-2:0], (cnt >= CNT_DASH)};
        len     <= len + 4'd1;
      end else if (len == LEN_MAX) begin
        len <= LEN_MAX + 4'd1;
      end
    end
  end

  assign hi_zero   = (pattern >> 5) == '0;
  assign push      = letter_end | word_end;
  assign push_char = word_end ? ASCII_SPACE :
                     hi_zero  ? decode_char(len, pattern[4:0]) : ASCII_QMARK;
  assign load      = push && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_char  <= ASCII_SPACE;
      overflow  <= 1'b0;
    end else if (push) begin
      if (load) begin
        out_char  <= push_char;
        out_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MORSE_STREAM_SEG7_EN
  logic [6:0] seg_code;

  morse_seg7_enc u_seg7_enc (
    .char_code (push_char),
    .seg       (seg_code)
  );

  always_ff @(posedge clk) begin
    if (reset)     seg <= SEG_BLANK;
    else if (load) seg <= seg_code;
  end
`endif

endmodule

// File: doc/morse_stream_decoder.md
MORSE_STREAM_DECODER -- requirements
Module: morse_stream_decoder

Interface
REQ-001 SHALL have parameter DOT_CYCLES, default 1000, meaning the nominal dot duration in clk cycles (minimum 4).
REQ-002 SHALL have parameter GLITCH_CYCLES, default 2, meaning that marks shorter than this are discarded as noise (must be less than DOT_CYCLES).
REQ-003 SHALL have parameter MAX_LEN, default 6, meaning the maximum number of elements per letter (range 5..8).
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port morse_in, input, 1 bit: asynchronous key line; 1 = mark.
REQ-007 SHALL have port out_valid, output, 1 bit: out_char holds a decoded character.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts out_char.
REQ-009 SHALL have port out_char, output, 8 bits: ASCII 'A'-'Z', '0'-'9', ' ' (word end) or '?' (unknown).
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag; a character was dropped.
REQ-011 SHALL have port seg, output, 7 bits: active-low 7-segment code; present only with MORSE_STREAM_SEG7_EN.

Function
REQ-012 morse_in SHALL pass through a 2-flop synchroniser; all timing SHALL be measured on the synchronised signal m.
REQ-013 The FSM states SHALL be IDLE, MARK, GAP and WORD_WAIT.
- IDLE -> MARK on rising m.
- MARK -> GAP on falling m.
- GAP -> MARK on rising m.
- GAP -> WORD_WAIT at letter end.
- WORD_WAIT -> MARK on rising m.
- WORD_WAIT -> IDLE at word end.
REQ-014 A single counter SHALL count cycles in MARK/GAP/WORD_WAIT, clear on every m edge, and saturate at 8*DOT_CYCLES; its width SHALL be $clog2(8*DOT_CYCLES+1).
REQ-015 On MARK exit, a mark of length L < GLITCH_CYCLES SHALL be ignored; the FSM returns to its pre-mark state and the pattern is unchanged.
REQ-016 A mark with GLITCH_CYCLES <= L < 2*DOT_CYCLES SHALL be a dot (0); a mark with L >= 2*DOT_CYCLES SHALL be a dash (1).
- The element SHALL shift into an MAX_LEN-bit pattern register (LSB = newest), and the length register SHALL be incremented.
REQ-017 Letter end SHALL occur when the gap count reaches 2*DOT_CYCLES in GAP.
- The decoded character SHALL be pushed to the output register.
- The pattern and length registers SHALL then clear.
REQ-018 Word end SHALL occur when the count reaches 6*DOT_CYCLES in WORD_WAIT.
- ' ' SHALL be pushed exactly once per word.
- No space SHALL be emitted before the first letter after reset.
REQ-019 Decode SHALL match (length, pattern) against the 36-entry A-Z/0-9 table.
- No match SHALL yield '?'.
- Length above MAX_LEN (further elements beyond the MAX_LEN-th) SHALL force '?' and leave the pattern frozen.
REQ-020 The output register SHALL be single-entry with a valid/ready handshake.
- out_char SHALL be stable while out_valid=1 and out_ready=0.
- The transfer SHALL complete on a clk edge with out_valid and out_ready both 1.
REQ-021 A push SHALL set out_valid on the next edge, giving 1-cycle latency from the letter-end or word-end count.
REQ-022 A push and a transfer in the same cycle SHALL load the new character with out_valid staying 1.
REQ-023 A push while out_valid=1 without a transfer SHALL drop the new character and set overflow.
REQ-024 overflow SHALL clear only on reset.

Reset
REQ-025 On reset, the state SHALL be IDLE, with counter, pattern, length and synchroniser at 0, out_valid=0, out_char=8'h20, overflow=0, and seg=7'h7F.
REQ-026 Reset asserted mid-letter SHALL discard the partial pattern without emitting anything.

Configuration
REQ-027 With MORSE_STREAM_SEG7_EN defined, seg SHALL register the 7-segment code of each pushed character.
- Digits SHALL map to 0-9 glyphs.
- A-F SHALL map to hex glyphs.
- All other characters SHALL map to blank (7'h7F).
- Word end SHALL blank seg.
REQ-028 Without MORSE_STREAM_SEG7_EN, the seg port and its logic SHALL be absent.

Structure
REQ-029 Package morse_pkg SHALL hold:
- the state enum;
- the 36-entry code table {len[2:0], pattern[4:0]};
- the ASCII constants ' ' and '?';
- the 7-segment glyph table.
REQ-030 Sub-module morse_seg7_enc (combinational ASCII to 7-segment) SHALL be instantiated only under MORSE_STREAM_SEG7_EN.

Verification (DOT_CYCLES=4, GLITCH_CYCLES=2, out_ready=1 unless stated)
REQ-031 Mark 4, gap 4, mark 12, gap 40 -> out_char 0x41 ('A') 1 cycle after gap count 8, then 0x20 at gap count 24.
REQ-032 Five 12-cycle dashes with 4-cycle gaps, then gap 8 -> 0x30 ('0'); a 1-cycle pulse inside a gap -> no change.
REQ-033 Seven dots (MAX_LEN=6) -> 0x3F ('?'); pattern .-.-.- -> 0x3F.
REQ-034 out_ready=0; send "E", "T" -> out_char stays 0x45, overflow=1; then out_ready=1 -> one transfer of 0x45.
REQ-035 Reset pulsed after 2 dots; then mark 12, gap 40 -> only 0x54 ('T') and 0x20.
REQ-036 With MORSE_STREAM_SEG7_EN: 'B' (-...) -> seg 7'b0000011; word end -> seg 7'h7F.
